jam_gen: RTL and testbench
==========================

JAM_GEN -- requirements
Module: jam_gen

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of workers and jobs; legal range 2..8.
REQ-002 The block SHALL have parameter CW, default 7, giving the Cost width in bits.
REQ-003 The block SHALL use derived widths IW = clog2(N) (minimum 1), SW = CW + clog2(N) + 1 and MW = 16.
REQ-004 CLK  input  1  clock; all state SHALL change on the rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a search; sampled only while idle.
REQ-007 mode  input  1  search objective, 0 = minimum, 1 = maximum; latched on an accepted start.
REQ-008 W  output  IW  worker index of the current cost query.
REQ-009 J  output  IW  job index of the current cost query.
REQ-010 Cost  input  CW  cost of (W, J); combinational from the external table and valid in the same cycle as W and J.
REQ-011 busy  output  1  high from the cycle after an accepted start until the cycle Valid is high, inclusive.
REQ-012 Valid  output  1  one-cycle pulse marking the final result.
REQ-013 BestCost  output  SW  best total cost found.
REQ-014 MatchCount  output  MW  number of permutations achieving BestCost.
REQ-015 BestPerm  output  N*IW  job assigned to worker i, held at bits [i*IW +: IW].

Function
REQ-016 The block SHALL use the states IDLE, LOAD, SUM, NEXT and DONE.
  - IDLE goes to LOAD on start.
  - LOAD goes to SUM.
  - SUM goes to NEXT after N cycles, or to DONE if the permutation just summed is the last one.
  - NEXT goes to SUM.
  - DONE goes to IDLE.
REQ-017 In LOAD the block SHALL set perm to the identity permutation and clear the running sum.
  - BestCost SHALL be set to all-ones when mode = 0 and to 0 when mode = 1.
  - MatchCount SHALL be set to 0.
REQ-018 In SUM cycle k (k = 0..N-1) the block SHALL drive W = k and J = perm[k], and accumulate Cost into an SW-bit sum.
  - Overflow is impossible by the choice of SW.
REQ-019 Outside SUM, W and J SHALL be 0.
REQ-020 In the SUM cycle with k = N-1, total = sum + Cost SHALL be compared against BestCost and the registers updated at that clock edge:
  - mode 0 and total < BestCost, or mode 1 and total > BestCost: BestCost <= total, MatchCount <= 1, BestPerm <= perm.
  - total == BestCost: MatchCount increments, saturating at 2^MW-1; BestPerm is unchanged, so the lexicographically first best permutation is kept.
REQ-021 NEXT SHALL produce the lexicographic successor of perm in the standard way:
  - find the rightmost pivot p with perm[p] < perm[p+1];
  - swap perm[p] with the smallest element to its right that is greater than perm[p];
  - reverse the elements perm[p+1..N-1].
REQ-022 NEXT SHALL complete within at most 2N+2 cycles.
REQ-023 NEXT SHALL not modify BestCost, MatchCount or BestPerm.
REQ-024 The last permutation SHALL be detected as no pivot existing (perm strictly descending), evaluated after its SUM pass.
  - Exactly N! permutations SHALL be summed, each once.
REQ-025 Valid SHALL be high for exactly the one cycle in DONE.
REQ-026 BestCost, MatchCount and BestPerm SHALL be stable from DONE until the next accepted start.
REQ-027 A start asserted while busy SHALL be ignored, with no effect on the running search.
REQ-028 mode changes while busy SHALL be ignored; only the value latched at start applies.
REQ-029 For N = 2 the search SHALL sum exactly 2 permutations and reach DONE.

Reset
REQ-030 While RST is high, state SHALL be IDLE and perm the identity permutation.
REQ-031 While RST is high, the outputs SHALL be: BestCost all-ones, MatchCount 0, BestPerm identity, busy 0, Valid 0, W 0, J 0.
REQ-032 RST asserted mid-search SHALL abort the search immediately with no Valid pulse.
  - After RST deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 N=4, Cost = 5 for all pairs, mode 0 -> BestCost 20, MatchCount 24, BestPerm {0,1,2,3}, Valid once, 24 SUM passes.
REQ-034 N=4, Cost = 0 if W==J else 10, mode 0 -> BestCost 0, MatchCount 1, BestPerm {0,1,2,3}.
REQ-035 Same table as REQ-034, mode 1 -> BestCost 40, MatchCount 9 (the derangements), BestPerm {1,0,3,2}.
REQ-036 N=8, Cost = 1 for all pairs -> BestCost 8, MatchCount 40320, no saturation, busy high throughout, exactly one Valid.
REQ-037 N=4: pulse start mid-search -> result identical to an undisturbed run.
  - Assert RST during NEXT -> no Valid, all outputs at reset values; a fresh start then gives the correct result.

Source files
------------

// File: rtl/jam_gen.sv
// Exhaustive assignment search: walks all N! job permutations in lexicographic order,
// summing Cost(W,J) per worker and keeping the min/max total, its match count and first best permutation.
// One permutation per N+1 cycles (N SUM cycles + 1 NEXT cycle); start is ignored while busy.
module jam_gen #(
  parameter int N  = 8,
  parameter int CW = 7,
  localparam int IW = ($clog2(N) < 1) ? 1 : $clog2(N),
  localparam int SW = CW + $clog2(N) + 1,
  localparam int MW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              mode,
  output logic [IW-1:0]     W,
  output logic [IW-1:0]     J,
  input  logic [CW-1:0]     Cost,
  output logic              busy,
  output logic              Valid,
  output logic [SW-1:0]     BestCost,
  output logic [MW-1:0]     MatchCount,
  output logic [N*IW-1:0]   BestPerm
);

  typedef enum logic [2:0] {IDLE, LOAD, SUM, NEXT, DONE} state_t;

  function automatic logic [N*IW-1:0] identity_perm();
    logic [N*IW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*IW +: IW] = IW'(i);
    return p;
  endfunction

  localparam logic [N*IW-1:0] IDENT = identity_perm();
  localparam logic [IW-1:0]   KLAST = IW'(N - 1);

  state_t          state_q, state_d;
  logic [N*IW-1:0] perm_q;
  logic [N*IW-1:0] swapped;
  logic [N*IW-1:0] nxt_perm;
  logic [IW-1:0]   k_q;
  logic [IW-1:0]   j_sel;
  logic [SW-1:0]   sum_q;
  logic [SW-1:0]   total;
  logic [SW-1:0]   best_q;
  logic [MW-1:0]   match_q;
  logic [N*IW-1:0] bperm_q;
  logic            mode_q;
  logic            k_last;
  logic            has_pivot;
  logic            better;
  int              piv;
  int              succ;
  logic [IW-1:0]   pv;
  logic [IW-1:0]   sv;

  assign k_last     = (k_q == KLAST);
  assign total      = sum_q + SW'(Cost);
  assign better     = mode_q ? (total > best_q) : (total < best_q);
  assign BestCost   = best_q;
  assign MatchCount = match_q;
  assign BestPerm   = bperm_q;

  // State register; reset aborts any search in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the state-decoded outputs (query address, busy, Valid).
  always_comb begin
    state_d = state_q;
    W       = '0;
    J       = '0;
    busy    = (state_q != IDLE);
    Valid   = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = SUM;
      SUM: begin
        W = k_q;
        J = j_sel;
        if (k_last) state_d = has_pivot ? NEXT : DONE;
      end
      NEXT: state_d = SUM;
      DONE: begin
        Valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job currently assigned to worker k.
  always_comb begin
    j_sel = '0;
    for (int i = 0; i < N; i++)
      if (k_q == IW'(i)) j_sel = perm_q[i*IW +: IW];
  end

  // Lexicographic successor: rightmost ascent, swap with smallest larger suffix element, reverse suffix.
  always_comb begin
    has_pivot = 1'b0;
    piv       = 0;
    succ      = 0;
    pv        = '0;
    sv        = '0;
    for (int i = 0; i < N - 1; i++)
      if (perm_q[i*IW +: IW] < perm_q[(i+1)*IW +: IW]) begin
        has_pivot = 1'b1;
        piv       = i;
      end
    for (int i = 0; i < N; i++)
      if (i == piv) pv = perm_q[i*IW +: IW];
    // The suffix is descending, so the rightmost larger element is the smallest larger one.
    for (int i = 0; i < N; i++)
      if (i > piv && perm_q[i*IW +: IW] > pv) succ = i;
    for (int i = 0; i < N; i++)
      if (i == succ) sv = perm_q[i*IW +: IW];
    swapped = perm_q;
    for (int i = 0; i < N; i++) begin
      if (i == piv)       swapped[i*IW +: IW] = sv;
      else if (i == succ) swapped[i*IW +: IW] = pv;
    end
    nxt_perm = swapped;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i > piv && j == N + piv - i) nxt_perm[i*IW +: IW] = swapped[j*IW +: IW];
  end

  // Datapath: permutation, running sum and best-result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perm_q  <= IDENT;
      k_q     <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      best_q  <= '1;
      match_q <= '0;
      bperm_q <= IDENT;
    end else begin
      case (state_q)
        IDLE: if (start) mode_q <= mode;
        LOAD: begin
          perm_q  <= IDENT;
          sum_q   <= '0;
          k_q     <= '0;
          best_q  <= mode_q ? '0 : '1;
          match_q <= '0;
          // Seeding with identity keeps "first best" correct when the first total ties the seed.
          bperm_q <= IDENT;
        end
        SUM: begin
          if (k_last) begin
            k_q   <= '0;
            sum_q <= '0;
            if (better) begin
              best_q  <= total;
              match_q <= MW'(1);
              bperm_q <= perm_q;
            end else if (total == best_q) begin
              if (match_q != '1) match_q <= match_q + MW'(1);
            end
          end else begin
            k_q   <= k_q + IW'(1);
            sum_q <= total;
          end
        end
        NEXT: perm_q <= nxt_perm;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_gen.sv
module tb_jam_gen;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  // N=4 instance: two selectable cost tables.
  logic        start4 = 1'b0, mode4 = 1'b0;
  logic [1:0]  w4, j4;
  logic [6:0]  cost4;
  logic        busy4, valid4;
  logic [9:0]  best4;
  logic [15:0] match4;
  logic [7:0]  perm4;
  int          tbl4 = 0;
  assign cost4 = (tbl4 == 0) ? 7'd5 : ((w4 == j4) ? 7'd0 : 7'd10);

  // N=2 instance: diagonal 3, off-diagonal 1.
  logic        start2 = 1'b0, mode2 = 1'b0;
  logic        w2, j2;
  logic [6:0]  cost2;
  logic        busy2, valid2;
  logic [8:0]  best2;
  logic [15:0] match2;
  logic [1:0]  perm2;
  assign cost2 = (w2 == j2) ? 7'd3 : 7'd1;

  // N=6 instance: uniform cost 1.
  logic        start6 = 1'b0, mode6 = 1'b0;
  logic [2:0]  w6, j6;
  logic [6:0]  cost6;
  logic        busy6, valid6;
  logic [10:0] best6;
  logic [15:0] match6;
  logic [17:0] perm6;
  assign cost6 = (j6 < 3'd6) ? 7'd1 : 7'd0;

  jam_gen #(.N(4), .CW(7)) dut4 (.CLK(CLK), .RST(RST), .start(start4), .mode(mode4), .W(w4), .J(j4),
    .Cost(cost4), .busy(busy4), .Valid(valid4), .BestCost(best4), .MatchCount(match4), .BestPerm(perm4));
  jam_gen #(.N(2), .CW(7)) dut2 (.CLK(CLK), .RST(RST), .start(start2), .mode(mode2), .W(w2), .J(j2),
    .Cost(cost2), .busy(busy2), .Valid(valid2), .BestCost(best2), .MatchCount(match2), .BestPerm(perm2));
  jam_gen #(.N(6), .CW(7)) dut6 (.CLK(CLK), .RST(RST), .start(start6), .mode(mode6), .W(w6), .J(j6),
    .Cost(cost6), .busy(busy6), .Valid(valid6), .BestCost(best6), .MatchCount(match6), .BestPerm(perm6));

  typedef struct {
    int          dut;
    logic [63:0] best;
    logic [63:0] match;
    logic [63:0] perm;
    int          passes;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          passes [3];
  int          done_cnt [3];
  logic [63:0] best_v [3];
  logic [63:0] match_v [3];
  logic [63:0] perm_v [3];
  logic        valid_v [3];
  logic        busy_v [3];
  logic        wlast_v [3];

  assign best_v[0] = 64'(best4);   assign best_v[1] = 64'(best2);   assign best_v[2] = 64'(best6);
  assign match_v[0] = 64'(match4); assign match_v[1] = 64'(match2); assign match_v[2] = 64'(match6);
  assign perm_v[0] = 64'(perm4);   assign perm_v[1] = 64'(perm2);   assign perm_v[2] = 64'(perm6);
  assign valid_v[0] = valid4;      assign valid_v[1] = valid2;      assign valid_v[2] = valid6;
  assign busy_v[0] = busy4;        assign busy_v[1] = busy2;        assign busy_v[2] = busy6;
  assign wlast_v[0] = (w4 == 2'd3); assign wlast_v[1] = (w2 == 1'b1); assign wlast_v[2] = (w6 == 3'd5);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input int d, input logic [63:0] b, input logic [63:0] m,
                               input logic [63:0] p, input int np);
    exp_t e;
    e.dut = d; e.best = b; e.match = m; e.perm = p; e.passes = np;
    q.push_back(e);
  endtask

  // Monitor: counts SUM passes and scores every Valid pulse against the queue.
  always @(negedge CLK) begin
    if (RST) begin
      for (int d = 0; d < 3; d++) passes[d] = 0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (wlast_v[d]) passes[d]++;
        if (valid_v[d]) begin
          if (q.size() == 0) begin
            check("spurious_valid", 64'(valid_v[d]), 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("result_dut", 64'(d), 64'(e.dut));
            check("best_cost", best_v[d], e.best);
            check("match_count", match_v[d], e.match);
            check("best_perm", perm_v[d], e.perm);
            check("sum_passes", 64'(passes[d]), 64'(e.passes));
            check("busy_at_valid", 64'(busy_v[d]), 64'd1);
          end
          passes[d] = 0;
          done_cnt[d]++;
        end
      end
    end
  end

  task automatic pulse_start(input int d, input logic m);
    @(posedge CLK); #1;
    case (d)
      0: begin start4 = 1'b1; mode4 = m; end
      1: begin start2 = 1'b1; mode2 = m; end
      default: begin start6 = 1'b1; mode6 = m; end
    endcase
    @(posedge CLK); #1;
    start4 = 1'b0; start2 = 1'b0; start6 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int d0;
    int c;
    d0 = done_cnt[d];
    c = 0;
    while (done_cnt[d] == d0 && c < budget) begin
      @(posedge CLK);
      c++;
    end
    check("done_within_budget", 64'(done_cnt[d] != d0), 64'd1);
  endtask

  task automatic check_idle4(input string tag, input logic [63:0] b);
    @(posedge CLK); #1;
    check({tag, "_busy_low"}, 64'(busy4), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    check({tag, "_best_stable"}, 64'(best4), b);
  endtask

  task automatic check_reset4(input string tag);
    check({tag, "_best"}, 64'(best4), 64'd1023);
    check({tag, "_match"}, 64'(match4), 64'd0);
    check({tag, "_perm"}, 64'(perm4), 64'hE4);
    check({tag, "_busy"}, 64'(busy4), 64'd0);
    check({tag, "_valid"}, 64'(valid4), 64'd0);
    check({tag, "_w"}, 64'(w4), 64'd0);
    check({tag, "_j"}, 64'(j4), 64'd0);
  endtask

  initial begin
    int  c;
    for (int d = 0; d < 3; d++) begin passes[d] = 0; done_cnt[d] = 0; end
    #2 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset4("rst4");
    check("rst2_best", 64'(best2), 64'd511);
    check("rst2_perm", 64'(perm2), 64'd2);
    check("rst6_best", 64'(best6), 64'd2047);
    check("rst6_perm", 64'(perm6), 64'h2C688);
    RST = 1'b0;

    // Uniform cost 5: every permutation ties.
    tbl4 = 0;
    expect_result(0, 64'd20, 64'd24, 64'hE4, 24);
    pulse_start(0, 1'b0);
    wait_done(0, 2000);
    check_idle4("uniform", 64'd20);

    // Diagonal-zero table, minimum: identity is the unique optimum.
    tbl4 = 1;
    expect_result(0, 64'd0, 64'd1, 64'hE4, 24);
    pulse_start(0, 1'b0);
    wait_done(0, 2000);
    check_idle4("diag_min", 64'd0);

    // Same table, maximum: the 9 derangements, first is {1,0,3,2}.
    expect_result(0, 64'd40, 64'd9, 64'hB1, 24);
    pulse_start(0, 1'b1);
    wait_done(0, 2000);
    check_idle4("diag_max", 64'd40);

    // Extra starts and mode flips while busy must not disturb the search.
    expect_result(0, 64'd40, 64'd9, 64'hB1, 24);
    pulse_start(0, 1'b1);
    repeat (10) @(posedge CLK);
    #1; start4 = 1'b1; mode4 = 1'b0;
    @(posedge CLK); #1; start4 = 1'b0;
    repeat (37) @(posedge CLK);
    #1; start4 = 1'b1;
    @(posedge CLK); #1; start4 = 1'b0;
    wait_done(0, 2000);
    check_idle4("busy_start", 64'd40);

    // Reset while in NEXT: abort, no Valid, reset values on outputs.
    pulse_start(0, 1'b0);
    c = 0;
    while (c < 200) begin
      @(negedge CLK);
      if (w4 == 2'd3) break;
      c++;
    end
    check("reached_last_sum", 64'(c < 200), 64'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check_reset4("abort");
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    check("abort_stays_idle", 64'(busy4), 64'd0);
    expect_result(0, 64'd0, 64'd1, 64'hE4, 24);
    pulse_start(0, 1'b0);
    wait_done(0, 2000);

    // N=2: two permutations only.
    expect_result(1, 64'd2, 64'd1, 64'd1, 2);
    pulse_start(1, 1'b0);
    wait_done(1, 200);
    expect_result(1, 64'd6, 64'd1, 64'd2, 2);
    pulse_start(1, 1'b1);
    wait_done(1, 200);

    // N=6, uniform cost: all 720 permutations tie.
    expect_result(2, 64'd6, 64'd720, 64'h2C688, 720);
    pulse_start(2, 1'b0);
    wait_done(2, 8000);

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
